hwpe_cmd_issuer: RTL and testbench

Command issuer between the host-side instruction source and the HWPE accelerator's RoCC-style command port. It buffers 96-bit instruction words ({inst, rs1, rs2}, the same format written to instr.txt), checks the custom-0 opcode, and issues them in order. For instructions with xd=1 (racc), it stalls until the accelerator returns the response. It then forwards the read data, tagged with accreg/PE ids, on an output stream for checking or writeback.

---
 rtl/hwpe_cmd_issuer.sv | 157 +++++++++++++++
 tb/tb_hwpe_cmd_issuer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_cmd_issuer.sv
// In-order issuer of buffered 96-bit RoCC instruction words to the HWPE accelerator.
// Commands with xd=1 stall issue until the response is captured into the readback register.
module hwpe_cmd_issuer #(
   parameter int          DEPTH  = 16,
   parameter logic [6:0]  OPCODE = 7'b0001011
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [95:0] in_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_inst,
   output logic [31:0] cmd_rs1,
   output logic [31:0] cmd_rs2,
   input  logic        resp_valid,
   output logic        resp_ready,
   input  logic [4:0]  resp_rd,
   input  logic [31:0] resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [9:0]  out_tag,
   output logic [15:0] cmd_cnt,
   output logic [15:0] resp_cnt,
   output logic        err_opcode,
   output logic        err_unexp,
   output logic        idle,
   output logic        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // a raised valid is held with stable payload until that transfer.

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      ST_ISSUE = 1'b0,
      ST_WAIT  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [95:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        init_q;
   logic [9:0]  pend_tag_q, pend_tag_d;
   logic [9:0]  out_tag_q;
   logic [31:0] out_data_q;
   logic        out_valid_q;
   logic [15:0] cmd_cnt_q, resp_cnt_q;
   logic        err_opcode_q, err_unexp_q;

   logic [95:0] head;
   logic [31:0] head_inst;
   logic        empty, full, head_legal;
   logic        push, pop, cmd_fire, drop, capture, unexp;
   logic        unused_resp_rd;

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign head_inst  = head[95:64];
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_legal = (head_inst[6:0] == OPCODE);
   assign unused_resp_rd = ^resp_rd;

   always_comb begin
      state_d    = state_q;
      pend_tag_d = pend_tag_q;
      cmd_valid  = 1'b0;
      drop       = 1'b0;
      resp_ready = 1'b1;
      capture    = 1'b0;
      unexp      = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            if (!empty) begin
               if (head_legal) cmd_valid = 1'b1;
               else            drop      = 1'b1;
            end
            if (cmd_valid && cmd_ready && head_inst[14]) begin
               state_d    = ST_WAIT;
               pend_tag_d = {head_inst[19:15], head_inst[24:20]};
            end
            unexp = resp_valid;
         end
         ST_WAIT: begin
            // Readback register doubles as the backpressure point toward the accelerator.
            resp_ready = !out_valid_q;
            if (resp_valid && !out_valid_q) begin
               capture = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_ISSUE;
      endcase
   end

   assign cmd_fire = cmd_valid && cmd_ready;
   assign pop      = cmd_fire || drop;
   // A full FIFO still takes a word in a cycle that frees the head slot.
   assign in_ready = init_q && (!full || pop);
   assign push     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ISSUE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         init_q       <= 1'b0;
         pend_tag_q   <= '0;
         out_tag_q    <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         cmd_cnt_q    <= '0;
         resp_cnt_q   <= '0;
         err_opcode_q <= 1'b0;
         err_unexp_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_q     <= 1'b1;
         pend_tag_q <= pend_tag_d;
         if (push)     wr_ptr_q  <= wr_ptr_q + 1'b1;
         if (pop)      rd_ptr_q  <= rd_ptr_q + 1'b1;
         if (cmd_fire) cmd_cnt_q <= cmd_cnt_q + 16'd1;
         if (drop)     err_opcode_q <= 1'b1;
         if (unexp)    err_unexp_q  <= 1'b1;
         if (capture) begin
            out_valid_q <= 1'b1;
            out_data_q  <= resp_data;
            out_tag_q   <= pend_tag_q;
            resp_cnt_q  <= resp_cnt_q + 16'd1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign cmd_inst   = head_inst;
   assign cmd_rs1    = head[63:32];
   assign cmd_rs2    = head[31:0];
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_tag    = out_tag_q;
   assign cmd_cnt    = cmd_cnt_q;
   assign resp_cnt   = resp_cnt_q;
   assign err_opcode = err_opcode_q;
   assign err_unexp  = err_unexp_q;
   assign idle       = empty && (state_q == ST_ISSUE) && !out_valid_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_hwpe_cmd_issuer.sv
// Bench for hwpe_cmd_issuer: cycle engine drives host, accelerator and consumer,
// and compares every observable against a queue-based model of the issuer.
module tb_hwpe_cmd_issuer;

   localparam int DEPTH = 16;
   localparam logic [6:0] OPC = 7'b0001011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [95:0] in_data = '0;
   logic        cmd_valid, cmd_ready = 1'b0;
   logic [31:0] cmd_inst, cmd_rs1, cmd_rs2;
   logic        resp_valid = 1'b0, resp_ready;
   logic [4:0]  resp_rd = '0;
   logic [31:0] resp_data = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_data;
   logic [9:0]  out_tag;
   logic [15:0] cmd_cnt, resp_cnt;
   logic        err_opcode, err_unexp, idle, dbg_state;

   always #5 clk = ~clk;

   hwpe_cmd_issuer #(.DEPTH(DEPTH), .OPCODE(OPC)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_inst(cmd_inst), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rd(resp_rd), .resp_data(resp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag),
      .cmd_cnt(cmd_cnt), .resp_cnt(resp_cnt),
      .err_opcode(err_opcode), .err_unexp(err_unexp),
      .idle(idle), .dbg_state(dbg_state)
   );

   int n_vec = 0;
   int n_err = 0;

   // model state
   logic [95:0] src_q[$];
   logic [95:0] mq[$];
   logic [41:0] exp_q[$];
   bit          m_wait;
   int          cdown;
   logic [9:0]  m_tag;
   logic [31:0] cur_rd;
   int          m_cmd, m_resp, n_out, n_push, cyc;
   int          cmd_mode, out_mode, push_mode, fixed_delay;

   task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [95:0] w);
      logic [31:0] inst;
      inst = w[95:64];
      return (inst % 128) == 32'(OPC);
   endfunction

   function automatic bit xd_of(input logic [95:0] w);
      logic [31:0] inst;
      inst = w[95:64];
      return ((inst >> 14) % 2) == 1;
   endfunction

   function automatic logic [9:0] tag_of(input logic [95:0] w);
      logic [31:0] inst;
      int acc, pe;
      inst = w[95:64];
      acc  = int'((inst >> 15) % 32);
      pe   = int'((inst >> 20) % 32);
      return 10'(acc * 32 + pe);
   endfunction

   function automatic logic [95:0] mk(input bit racc);
      logic [31:0] inst;
      inst = $urandom;
      inst = (inst & ~32'h7F) | 32'(OPC);
      inst = racc ? (inst | 32'h4000) : (inst & ~32'h4000);
      return {inst, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_wait = 0;
      cdown  = 0;
      m_tag  = '0;
      m_cmd  = 0;
      m_resp = 0;
   endtask

   // One clock: drive at the falling edge, sample 1 ns later, then advance the model.
   task automatic cycle();
      bit exp_cv, exp_drop, cfire, pop, exp_ir, exp_rr, rfire, ofire, push_ev, exp_idle;
      logic [95:0] h;
      @(negedge clk);
      cyc++;
      in_valid   = (src_q.size() > 0) &&
                   (push_mode == 1 || (push_mode == 2 && $urandom_range(0, 2) != 0));
      in_data    = (src_q.size() > 0) ? src_q[0] : 96'h0;
      cmd_ready  = (cmd_mode == 1) || (cmd_mode == 2 && $urandom_range(0, 1) == 1);
      resp_valid = m_wait && (cdown == 0);
      resp_data  = cur_rd;
      resp_rd    = 5'($urandom);
      out_ready  = (out_mode == 1) ||
                   (out_mode == 2 && (cyc % 37) >= 5 && $urandom_range(0, 3) != 0);
      #1;
      exp_cv   = !m_wait && mq.size() > 0 && legal(mq[0]);
      exp_drop = !m_wait && mq.size() > 0 && !legal(mq[0]);
      cfire    = exp_cv && cmd_ready;
      pop      = cfire || exp_drop;
      exp_ir   = (mq.size() < DEPTH) || pop;
      exp_rr   = m_wait ? (exp_q.size() == 0) : 1'b1;
      rfire    = m_wait && resp_valid && exp_rr;
      ofire    = (exp_q.size() > 0) && out_ready;
      push_ev  = in_valid && exp_ir;
      exp_idle = (mq.size() == 0) && !m_wait && (exp_q.size() == 0);

      chk("cmd_valid", 96'(cmd_valid), 96'(exp_cv));
      if (exp_cv) chk("cmd_fields", {cmd_inst, cmd_rs1, cmd_rs2}, mq[0]);
      chk("in_ready", 96'(in_ready), 96'(exp_ir));
      chk("resp_ready", 96'(resp_ready), 96'(exp_rr));
      chk("out_valid", 96'(out_valid), 96'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("out_tag_data", 96'({out_tag, out_data}), 96'(exp_q[0]));
      chk("cmd_cnt", 96'(cmd_cnt), 96'(16'(m_cmd)));
      chk("resp_cnt", 96'(resp_cnt), 96'(16'(m_resp)));
      chk("idle", 96'(idle), 96'(exp_idle));

      if (ofire) begin
         void'(exp_q.pop_front());
         n_out++;
      end
      if (rfire) begin
         exp_q.push_back({m_tag, resp_data});
         m_resp++;
         m_wait = 0;
      end else if (m_wait && cdown > 0) begin
         cdown--;
      end
      if (pop) begin
         h = mq.pop_front();
         if (cfire) begin
            m_cmd++;
            if (xd_of(h)) begin
               m_wait = 1;
               m_tag  = tag_of(h);
               cdown  = (fixed_delay > 0) ? fixed_delay - 1 : int'($urandom_range(0, 3));
               cur_rd = $urandom;
            end
         end
      end
      if (push_ev) begin
         mq.push_back(src_q.pop_front());
         n_push++;
      end
   endtask

   task automatic drain(input int budget);
      int b;
      b = budget;
      while ((src_q.size() > 0 || mq.size() > 0 || m_wait || exp_q.size() > 0) && b > 0) begin
         cycle();
         b--;
      end
      chk("drain_timeout", 96'(b == 0), 96'(0));
   endtask

   initial begin
      int base_cmd, base_resp, base_push, b;
      model_reset();
      cyc = 0; n_out = 0; n_push = 0; cur_rd = '0;
      cmd_mode = 1; out_mode = 1; push_mode = 1; fixed_delay = 0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cmd_valid", 96'(cmd_valid), 96'(0));
      chk("rst_out_valid", 96'(out_valid), 96'(0));
      chk("rst_out_data", 96'(out_data), 96'(0));
      chk("rst_out_tag", 96'(out_tag), 96'(0));
      chk("rst_cnts", 96'({cmd_cnt, resp_cnt}), 96'(0));
      chk("rst_errs", 96'({err_opcode, err_unexp}), 96'(0));
      chk("rst_idle", 96'(idle), 96'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // single wcfg
      src_q.push_back({32'h0400300B, 32'h00400008, 32'h00800210});
      drain(20);
      cycle();
      chk("wcfg_cmd_cnt", 96'(cmd_cnt), 96'(1));
      chk("wcfg_idle", 96'(idle), 96'(1));

      // racc_en answered three cycles after the handshake
      fixed_delay = 3;
      src_q.push_back({32'h20FBC00B, 32'h00000001, 32'h00000002});
      cycle(); cycle();
      cur_rd = 32'hDEADBEEF;
      drain(30);
      chk("racc_resp_cnt", 96'(resp_cnt), 96'(1));
      chk("racc_n_out", 96'(n_out), 96'(1));

      // 128 racc + 8 relu, random cmd_ready, periodic out_ready stalls
      fixed_delay = 0; cmd_mode = 2; out_mode = 2; push_mode = 2;
      base_cmd = m_cmd; base_resp = m_resp; n_out = 0;
      for (int i = 0; i < 136; i++) src_q.push_back(mk((i % 17) != 5));
      drain(6000);
      cycle();
      chk("stream_n_out", 96'(n_out), 96'(128));
      chk("stream_cmd_cnt", 96'(cmd_cnt), 96'(16'(base_cmd + 136)));
      chk("stream_resp_cnt", 96'(resp_cnt), 96'(16'(base_resp + 128)));

      // fill with cmd_ready low, then one push+pop at full
      cmd_mode = 0; out_mode = 1; push_mode = 1;
      base_push = n_push;
      for (int i = 0; i < DEPTH + 2; i++) src_q.push_back(mk(1'b0));
      repeat (DEPTH + 4) cycle();
      chk("fill_accepted", 96'(n_push - base_push), 96'(DEPTH));
      cmd_mode = 1;
      cycle();
      cmd_mode = 0;
      repeat (3) cycle();
      chk("full_swap_accepted", 96'(n_push - base_push), 96'(DEPTH + 1));
      chk("full_in_ready", 96'(in_ready), 96'(0));
      cmd_mode = 1;
      drain(60);

      // illegal opcode dropped, wcfg behind it issues
      chk("pre_err_opcode", 96'(err_opcode), 96'(0));
      base_cmd = m_cmd;
      src_q.push_back({32'h04000033, 32'h11111111, 32'h22222222});
      src_q.push_back({32'h0400300B, 32'h33333333, 32'h44444444});
      drain(20);
      cycle();
      chk("bad_err_opcode", 96'(err_opcode), 96'(1));
      chk("bad_cmd_cnt", 96'(cmd_cnt), 96'(16'(base_cmd + 1)));

      // unexpected response in ISSUE
      chk("pre_err_unexp", 96'(err_unexp), 96'(0));
      @(negedge clk);
      resp_valid = 1'b1;
      resp_data  = 32'hBADBAD00;
      #1;
      chk("unexp_resp_ready", 96'(resp_ready), 96'(1));
      @(negedge clk);
      resp_valid = 1'b0;
      #1;
      chk("unexp_err", 96'(err_unexp), 96'(1));
      chk("unexp_resp_cnt", 96'(resp_cnt), 96'(16'(m_resp)));
      chk("unexp_out_valid", 96'(out_valid), 96'(0));

      // reset asserted while waiting for a response
      fixed_delay = 100;
      src_q.push_back(mk(1'b1));
      src_q.push_back(mk(1'b0));
      b = 10;
      while (!m_wait && b > 0) begin cycle(); b--; end
      chk("reach_wait", 96'(m_wait), 96'(1));
      repeat (3) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cmd_valid", 96'(cmd_valid), 96'(0));
      chk("arst_out", 96'({out_valid, out_tag, out_data}), 96'(0));
      chk("arst_cnts", 96'({cmd_cnt, resp_cnt}), 96'(0));
      chk("arst_errs", 96'({err_opcode, err_unexp}), 96'(0));
      chk("arst_idle", 96'(idle), 96'(1));
      chk("arst_resp_ready", 96'(resp_ready), 96'(1));
      chk("arst_in_ready", 96'(in_ready), 96'(0));
      chk("arst_state", 96'(dbg_state), 96'(0));
      model_reset();
      src_q.delete();
      fixed_delay = 0;
      in_valid = 1'b0; resp_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      src_q.push_back({32'h0400300B, 32'h55555555, 32'h66666666});
      drain(20);
      cycle();
      chk("post_rst_cmd_cnt", 96'(cmd_cnt), 96'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
